// File: rtl/stride_sched_pkg.sv
// Shared types and sizing helpers for the stride job scheduler and its arbiter.
package stride_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_W     = 4;
    localparam int DEF_STEPW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index width for n requesters; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from the pointer upward with
// wrap-around and reports the first active request.
module rr_arbiter
    import stride_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic [IW:0]   pos;
    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            cand = pos[IW-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stride_job_sched.sv
// Arbitrates counting jobs from NREQ requesters onto one shared stride counter,
// running each granted job from 0 to its limit and pulsing done to the owner.
module stride_job_sched
    import stride_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int W     = DEF_W,
    parameter int STEPW = DEF_STEPW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*STEPW-1:0] req_step,
    input  logic [NREQ*W-1:0]     req_limit,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [W-1:0]          count,
    output logic                  flag,
    output logic [NREQ-1:0]       done
);

    localparam int IW = idx_width(NREQ);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [STEPW-1:0]  step_q, step_d;
    logic [W-1:0]      limit_q, limit_d;
    logic [W-1:0]      count_q, count_d;
    logic [NREQ-1:0]   grant_q, grant_d;

    logic [STEPW-1:0]  step_arr  [NREQ];
    logic [W-1:0]      limit_arr [NREQ];

    logic [NREQ-1:0]   win_onehot;
    logic [IW-1:0]     win_idx;
    logic              win_valid;
    logic              owner_req;
    logic [IW-1:0]     next_ptr;
    logic [W:0]        sum;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign step_arr[gi]  = req_step[gi*STEPW +: STEPW];
            assign limit_arr[gi] = req_limit[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (win_onehot),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign owner_req = req[idx_q];
    assign next_ptr  = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    // One extra bit keeps the carry, so a wrapped sum still compares above the limit.
    assign sum       = {1'b0, count_q} + (W+1)'(step_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        step_d  = step_q;
        limit_d = limit_q;
        count_d = count_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = LOAD;
                    idx_d   = win_idx;
                    step_d  = (step_arr[win_idx] == '0) ? STEPW'(1) : step_arr[win_idx];
                    limit_d = limit_arr[win_idx];
                    count_d = '0;
                    grant_d = win_onehot;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                    ptr_d   = next_ptr;
                end else begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                    ptr_d   = next_ptr;
                end else if (count_q == limit_q) begin
                    state_d = DONE;
                end else if (sum > {1'b0, limit_q}) begin
                    count_d = limit_q;
                end else begin
                    count_d = sum[W-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            step_q  <= '0;
            limit_q <= '0;
            count_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            limit_q <= limit_d;
            count_q <= count_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);
    assign count = count_q;
    assign flag  = ((state_q == RUN) || (state_q == DONE)) && (count_q >= (limit_q >> 1));
    assign done  = (state_q == DONE) ? grant_q : '0;

endmodule

// File: tb/tb_stride_job_sched.sv
// Self-checking bench: a job-trajectory model predicts every cycle's outputs,
// and directed scenarios pin the model with literal count/grant sequences.
module tb_stride_job_sched;

    localparam int NREQ = 4, W = 4, STEPW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_step = '0;
    logic [15:0] req_limit = '0;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  count;
    logic        flag;
    logic [3:0]  done;

    always #5 clk = ~clk;

    stride_job_sched #(.NREQ(NREQ), .W(W), .STEPW(STEPW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_step  (req_step),
        .req_limit (req_limit),
        .grant     (grant),
        .busy      (busy),
        .count     (count),
        .flag      (flag),
        .done      (done)
    );

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    typedef int iq_t[$];
    iq_t obs_cnt, obs_flag, obs_gnt, exp_q;
    int  done_cnt [4];
    logic [3:0] prev_grant = '0;

    // Model: each granted job expands into its full list of cycles (phase, count).
    typedef struct {int ph; int cnt;} ent_t;   // ph: 0 LOAD, 1 RUN, 2 DONE
    ent_t traj[$];
    int   m_owner = 0, m_lim = 0, m_ptr = 0;

    task automatic start_job(input int j);
        ent_t e;
        int s, lim, c;
        s   = int'(req_step[j*4 +: 4]);
        lim = int'(req_limit[j*4 +: 4]);
        if (s == 0) s = 1;
        m_owner = j;
        m_lim   = lim;
        e.ph = 0; e.cnt = 0; traj.push_back(e);
        c = 0;
        forever begin
            e.ph = 1; e.cnt = c; traj.push_back(e);
            if (c == lim) break;
            c = c + s;
            if (c > lim) c = lim;
        end
        e.ph = 2; e.cnt = c; traj.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                traj.delete();
                m_ptr = 0;
            end else if (traj.size() != 0) begin
                if (traj[0].ph != 2 && !req[m_owner]) begin
                    traj.delete();
                    m_ptr = (m_owner + 1) % NREQ;
                end else begin
                    void'(traj.pop_front());
                    if (traj.size() == 0) m_ptr = (m_owner + 1) % NREQ;
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (req[(m_ptr + k) % NREQ]) begin
                        start_job((m_ptr + k) % NREQ);
                        break;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, on the falling edge.
    logic [3:0] e_grant, e_done;
    logic       e_busy, e_flag;
    int         e_count;
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                e_grant = '0; e_done = '0; e_busy = 1'b0; e_flag = 1'b0; e_count = 0;
                if (traj.size() != 0) begin
                    e_grant = 4'(1 << m_owner);
                    e_busy  = 1'b1;
                    e_count = traj[0].cnt;
                    e_flag  = (traj[0].ph != 0) && (traj[0].cnt >= m_lim / 2);
                    e_done  = (traj[0].ph == 2) ? e_grant : 4'b0;
                end
                n_total++;
                if (grant === e_grant && busy === e_busy && int'(count) == e_count &&
                    flag === e_flag && done === e_done) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_compare @%0t: got grant=%b busy=%b count=%0d flag=%b done=%b, expected grant=%b busy=%b count=%0d flag=%b done=%b",
                             $time, grant, busy, count, flag, done, e_grant, e_busy, e_count, e_flag, e_done);
                end
                if (busy) begin
                    obs_cnt.push_back(int'(count));
                    obs_flag.push_back(int'(flag));
                end
                if (grant != 0 && prev_grant == 0) begin
                    for (int i = 0; i < NREQ; i++) if (grant[i]) obs_gnt.push_back(i);
                end
                prev_grant = grant;
                for (int i = 0; i < NREQ; i++) if (done[i] === 1'b1) done_cnt[i]++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_seq(input string name, input iq_t act, input iq_t exp);
        bit ok;
        int bad;
        ok  = (act.size() == exp.size());
        bad = -1;
        for (int i = 0; i < act.size() && i < exp.size(); i++) begin
            if (act[i] != exp[i] && bad < 0) begin
                bad = i;
                ok  = 1'b0;
            end
        end
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d entries, expected %0d; first difference at index %0d (got %0d, expected %0d)",
                      name, act.size(), exp.size(), bad,
                      (bad >= 0) ? act[bad] : -1, (bad >= 0) ? exp[bad] : -1);
    endtask

    task automatic timeout_fail(input string what);
        n_total++;
        $display("FAIL timeout %s: event not seen within cycle budget", what);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_grant"}, int'(grant), 0);
        check({pfx, "_busy"},  int'(busy),  0);
        check({pfx, "_count"}, int'(count), 0);
        check({pfx, "_flag"},  int'(flag),  0);
        check({pfx, "_done"},  int'(done),  0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int idx);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #2;
            if (done[idx] === 1'b1) seen = 1'b1;
        end
        if (!seen) timeout_fail($sformatf("done[%0d]", idx));
    endtask

    task automatic wait_count(input int v);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #2;
            if (busy === 1'b1 && int'(count) == v) seen = 1'b1;
        end
        if (!seen) timeout_fail($sformatf("count==%0d", v));
    endtask

    task automatic set_job(input int idx, input int step, input int lim);
        req_step[idx*4 +: 4]  = 4'(step);
        req_limit[idx*4 +: 4] = 4'(lim);
    endtask

    task automatic run_single(input int idx, input int step, input int lim);
        obs_cnt.delete();
        obs_flag.delete();
        set_job(idx, step, lim);
        req[idx] = 1'b1;
        wait_done(idx);
        req[idx] = 1'b0;
        idle(2);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2 check_zero("reset");
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        run_single(0, 3, 15);
        exp_q = '{0, 0, 3, 6, 9, 12, 15, 15};
        check_seq("t1_counts", obs_cnt, exp_q);
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1};
        check_seq("t1_flags", obs_flag, exp_q);

        run_single(1, 4, 10);
        exp_q = '{0, 0, 4, 8, 10, 10};
        check_seq("t2_saturate", obs_cnt, exp_q);

        run_single(2, 15, 14);
        exp_q = '{0, 0, 14, 14};
        check_seq("t3_overshoot", obs_cnt, exp_q);

        run_single(3, 9, 15);
        exp_q = '{0, 0, 9, 15, 15};
        check_seq("t3_carry", obs_cnt, exp_q);

        run_single(0, 0, 2);
        exp_q = '{0, 0, 1, 2, 2};
        check_seq("t4_step0", obs_cnt, exp_q);

        run_single(3, 5, 0);
        exp_q = '{0, 0, 0};
        check_seq("t5_limit0_counts", obs_cnt, exp_q);
        exp_q = '{0, 1, 1};
        check_seq("t5_limit0_flags", obs_flag, exp_q);

        obs_gnt.delete();
        for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
        set_job(0, 8, 8);
        set_job(2, 8, 8);
        req[0] = 1'b1;
        req[2] = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 300 && seen < 4; k++) begin
                @(posedge clk); #2;
                if (done[0] === 1'b1 || done[2] === 1'b1) seen++;
            end
            if (seen < 4) timeout_fail("four alternating jobs");
        end
        req = '0;
        idle(2);
        exp_q = '{0, 2, 0, 2};
        check_seq("alt_grant_order", obs_gnt, exp_q);
        check("alt_done0", done_cnt[0], 2);
        check("alt_done2", done_cnt[2], 2);
        check("alt_done_other", done_cnt[1] + done_cnt[3], 0);

        obs_cnt.delete();
        for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
        set_job(3, 3, 15);
        req[3] = 1'b1;
        wait_count(6);
        req[3] = 1'b0;
        idle(3);
        exp_q = '{0, 0, 3, 6};
        check_seq("abort_counts", obs_cnt, exp_q);
        check("abort_no_done3", done_cnt[3], 0);

        obs_gnt.delete();
        set_job(1, 1, 1);
        set_job(3, 1, 1);
        req[1] = 1'b1;
        req[3] = 1'b1;
        wait_done(1);
        req[1] = 1'b0;
        wait_done(3);
        req[3] = 1'b0;
        idle(2);
        exp_q = '{1, 3};
        check_seq("abort_ptr_order", obs_gnt, exp_q);

        set_job(0, 3, 15);
        req[0] = 1'b1;
        wait_count(9);
        #1 reset = 1'b1;
        #1 check_zero("midrst");
        obs_gnt.delete();
        set_job(2, 2, 3);
        set_job(3, 2, 3);
        req = 4'b1100;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        wait_done(2);
        req[2] = 1'b0;
        wait_done(3);
        req[3] = 1'b0;
        idle(2);
        exp_q = '{2, 3};
        check_seq("post_reset_order", obs_gnt, exp_q);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stride_job_sched.md
Name: stride_job_sched

Overview:
- Shares one stride counter between NREQ requesters.
- Each requester posts a counting job: a stride step and a terminal limit.
- A round-robin arbiter grants one job at a time. The block runs the counter from 0 to the limit in step increments.
- It raises a half-way flag, then pulses done back to the owning requester. It is the sequencer and arbiter in front of the small stride counters in the A1 datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, counter and limit width in bits
- STEPW, 4, step width in bits (STEPW <= W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  NREQ  per-requester job request level; hold high until done or abort
- req_step  in  NREQ*STEPW  packed per-requester step; slice i = [i*STEPW +: STEPW]
- req_limit  in  NREQ*W  packed per-requester terminal value; slice i = [i*W +: W]
- grant  out  NREQ  one-hot owner of the counter; all-zero when idle
- busy  out  1  high in LOAD, RUN, DONE
- count  out  W  current counter value
- flag  out  1  half-way indicator for the current job
- done  out  NREQ  one-cycle completion pulse to the owner

Behaviour:
- Reset, asynchronous: state=IDLE, grant=0, busy=0, count=0, flag=0, done=0, rr pointer=0.
- States:
  - IDLE: if any req, pick winner. LOAD next cycle.
  - LOAD: count=0.
  - RUN: counting.
  - DONE: completion cycle.
- Arbitration (IDLE only):
  - Round-robin; search starts at the pointer, lowest index first from there.
  - Winner index, step and limit latched on the IDLE->LOAD edge.
  - grant is registered and goes high in LOAD.
- Step rule: latched step 0 is replaced by 1, so every job terminates.
- LOAD: one cycle, grant[idx]=1, count=0, then RUN.
- RUN, each cycle:
  - If count == limit_q: go to DONE, count holds.
  - Else compute count + step in W+1 bits.
  - If the sum > limit_q, or the W+1 carry is set: count <= limit_q (saturate, no wrap).
  - Otherwise count <= sum.
- DONE: done[idx]=1 for exactly this cycle, grant still high. Next cycle:
  - grant=0, count=0, flag=0, IDLE.
  - Pointer <= idx+1 mod NREQ.
- flag: high when state is RUN or DONE and count >= (limit_q >> 1).
  - Decoded from registers only; no combinational path from inputs.
- Abort: if req[idx] drops in LOAD or RUN, next cycle:
  - IDLE, grant=0, count=0, flag=0, no done pulse.
  - Pointer <= idx+1.
- A req drop in DONE is ignored; done still pulses.
- limit 0: LOAD, then one RUN cycle with count==0==limit, then DONE.
- Non-owner req, step or limit changes during a job are ignored. The owner's step and limit are sampled only at grant.
- Reset mid-operation: immediate return to the reset values. A pending done is lost.
- A requester that is still high after DONE re-competes in IDLE. IDLE always lasts at least one cycle between jobs.

Decomposition:
- Package stride_sched_pkg holds:
  - state typedef enum {IDLE, LOAD, RUN, DONE}
  - default width constants
  - an index-width helper function (clog2 of NREQ)
- Sub-module rr_arbiter:
  - Inputs: NREQ req vector, pointer.
  - Outputs: one-hot winner, encoded index, valid.
  - Purely combinational.

Test Plan:
- W=4, req[0] with step 3, limit 15.
  - Response: grant[0] in LOAD; RUN counts 0,3,6,9,12,15.
  - flag rises when count=9.
  - done[0] pulses one cycle after the count=15 RUN cycle; grant drops the next cycle.
- req[1] with step 4, limit 10.
  - Response: counts 0,4,8,10 (saturated), then done[1].
  - step 15, limit 14: counts 0,14, then done (carry/overshoot check).
- req[0] and req[2] both held high continuously.
  - Response: grants in order 0, 2, 0, 2; exactly one done per job; grant always one-hot or zero.
- step 0, limit 2: counts 0,1,2, then done. limit 0: done two cycles after LOAD, flag high in RUN and DONE.
- Abort case: drop req[3] while count=6 (step 3, limit 15).
  - Response: next cycle IDLE, grant=0, count=0, no done[3]; the pointer moves on to 0.
- Reset case: assert reset asynchronously between clock edges while in RUN at count=9.
  - Response: all outputs 0 immediately, before the next edge.
  - After release, req[2] is granted first when req[2] and req[3] are both pending (pointer=0).
